// File: rtl/instr_buffer.sv
// Instruction buffer: in-order FIFO of {word, bank} with show-ahead head and per-bank occupancy.
// Optional macro INSTR_BUF_BYPASS_EN adds a zero-latency pass-through when the buffer is empty.
module instr_buffer #(
   parameter int unsigned STREAM_WIDTH = 128,
   parameter int unsigned NUM_BANKS    = 16,
   parameter int unsigned DEPTH        = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic [STREAM_WIDTH-1:0]       idata_instr,
   input  logic                          idata_instr_valid,
   input  logic [$clog2(NUM_BANKS)-1:0]  instr_bank_counter,
   output logic                          idata_instr_ready,
   output logic [STREAM_WIDTH-1:0]       instr_out,
   output logic [$clog2(NUM_BANKS)-1:0]  instr_out_bank,
   output logic                          instr_out_valid,
   input  logic                          instr_out_ready,
   output logic [$clog2(DEPTH):0]        count,
   output logic                          full,
   output logic                          empty,
   output logic [NUM_BANKS-1:0]          bank_pending
);

   localparam int unsigned BW = $clog2(NUM_BANKS);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [STREAM_WIDTH-1:0] r_mem_word [DEPTH];
   logic [BW-1:0]           r_mem_bank [DEPTH];
   logic [PW-1:0]           r_wr_ptr;
   logic [PW-1:0]           r_rd_ptr;
   logic [CW-1:0]           r_count;
   logic [CW-1:0]           r_bank_cnt [NUM_BANKS];

   logic                    w_push;
   logic                    w_pop;
   logic                    w_bypass;
   logic                    w_store;
   logic                    w_drain;
   logic [NUM_BANKS-1:0]    w_bank_inc;
   logic [NUM_BANKS-1:0]    w_bank_dec;

   assign count             = r_count;
   assign full              = (r_count == CW'(DEPTH));
   assign empty             = (r_count == '0);
   assign idata_instr_ready = !full && !flush;
   assign w_push            = idata_instr_valid && idata_instr_ready;

`ifdef INSTR_BUF_BYPASS_EN
   // Empty buffer forwards the input straight to the head port.
   assign w_bypass        = empty && !flush;
   assign instr_out_valid = w_bypass ? idata_instr_valid : !empty;
   assign instr_out       = w_bypass ? idata_instr : r_mem_word[r_rd_ptr];
   assign instr_out_bank  = w_bypass ? instr_bank_counter : r_mem_bank[r_rd_ptr];
`else
   assign w_bypass        = 1'b0;
   assign instr_out_valid = !empty;
   assign instr_out       = r_mem_word[r_rd_ptr];
   assign instr_out_bank  = r_mem_bank[r_rd_ptr];
`endif

   assign w_pop   = instr_out_valid && instr_out_ready;
   // A bypassed word consumed in the same cycle never touches storage.
   assign w_store = w_push && !(w_bypass && instr_out_ready);
   assign w_drain = w_pop && !w_bypass;

   // Storage array; contents survive flush, only pointers are cleared.
   always_ff @(posedge clk) begin
      if (w_store) begin
         r_mem_word[r_wr_ptr] <= idata_instr;
         r_mem_bank[r_wr_ptr] <= instr_bank_counter;
      end
   end

   // Pointers and total occupancy.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_store) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_drain) r_rd_ptr <= r_rd_ptr + PW'(1);
         if (w_store && !w_drain)      r_count <= r_count + CW'(1);
         else if (w_drain && !w_store) r_count <= r_count - CW'(1);
      end
   end

   always_comb begin
      w_bank_inc                             = '0;
      w_bank_dec                             = '0;
      w_bank_inc[instr_bank_counter]         = w_store;
      w_bank_dec[r_mem_bank[r_rd_ptr]]       = w_drain;
   end

   // Per-bank occupancy; a push and pop on the same bank cancel.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         for (int b = 0; b < NUM_BANKS; b++) r_bank_cnt[b] <= '0;
      end else begin
         for (int b = 0; b < NUM_BANKS; b++) begin
            if (w_bank_inc[b] && !w_bank_dec[b])      r_bank_cnt[b] <= r_bank_cnt[b] + CW'(1);
            else if (w_bank_dec[b] && !w_bank_inc[b]) r_bank_cnt[b] <= r_bank_cnt[b] - CW'(1);
         end
      end
   end

   always_comb begin
      bank_pending = '0;
      for (int b = 0; b < NUM_BANKS; b++) bank_pending[b] = (r_bank_cnt[b] != '0);
   end

endmodule

// File: tb/tb_instr_buffer.sv
// Self-checking bench for instr_buffer: directed scenarios plus random traffic against a queue model.
module tb_instr_buffer;

   localparam int unsigned SW    = 128;
   localparam int unsigned NB    = 16;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned BW    = 4;
   localparam int unsigned CW    = 4;
`ifdef INSTR_BUF_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic [SW-1:0] idata_instr;
   logic          idata_instr_valid;
   logic [BW-1:0] instr_bank_counter;
   logic          idata_instr_ready;
   logic [SW-1:0] instr_out;
   logic [BW-1:0] instr_out_bank;
   logic          instr_out_valid;
   logic          instr_out_ready;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;
   logic [NB-1:0] bank_pending;

   instr_buffer #(.STREAM_WIDTH(SW), .NUM_BANKS(NB), .DEPTH(DEPTH)) dut (
      .clk                (clk),
      .rst                (rst),
      .flush              (flush),
      .idata_instr        (idata_instr),
      .idata_instr_valid  (idata_instr_valid),
      .instr_bank_counter (instr_bank_counter),
      .idata_instr_ready  (idata_instr_ready),
      .instr_out          (instr_out),
      .instr_out_bank     (instr_out_bank),
      .instr_out_valid    (instr_out_valid),
      .instr_out_ready    (instr_out_ready),
      .count              (count),
      .full               (full),
      .empty              (empty),
      .bank_pending       (bank_pending)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [SW-1:0] w;
      logic [BW-1:0] b;
   } ent_t;

   ent_t q[$];
   int   errors = 0;
   int   checks = 0;

   task automatic check(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [SW-1:0] rand_word();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Drive one cycle, compare all outputs against the queue model, then advance the model.
   task automatic step(input logic v, input logic [SW-1:0] w, input logic [BW-1:0] b,
                       input logic rdy, input logic fl);
      int            sz;
      logic          byp, exp_ready, exp_valid, push, pop;
      logic [SW-1:0] hw;
      logic [BW-1:0] hb;
      logic [NB-1:0] pend;
      ent_t          e;
      idata_instr_valid  = v;
      idata_instr        = w;
      instr_bank_counter = b;
      instr_out_ready    = rdy;
      flush              = fl;
      #1;
      sz        = q.size();
      exp_ready = (sz < DEPTH) && !fl;
      byp       = BYP && (sz == 0) && !fl;
      exp_valid = byp ? v : (sz != 0);
      hw = '0;
      hb = '0;
      if (byp) begin
         hw = w;
         hb = b;
      end else if (sz != 0) begin
         hw = q[0].w;
         hb = q[0].b;
      end
      pend = '0;
      foreach (q[i]) pend[q[i].b] = 1'b1;
      check("ready", SW'(idata_instr_ready), SW'(exp_ready));
      check("valid", SW'(instr_out_valid), SW'(exp_valid));
      check("count", SW'(count), SW'(sz));
      check("full", SW'(full), SW'(sz == DEPTH));
      check("empty", SW'(empty), SW'(sz == 0));
      check("pending", SW'(bank_pending), SW'(pend));
      if (exp_valid) begin
         check("head_word", instr_out, hw);
         check("head_bank", SW'(instr_out_bank), SW'(hb));
      end
      push = v && exp_ready;
      pop  = exp_valid && rdy;
      @(posedge clk);
      if (fl) begin
         q.delete();
      end else if (!(byp && push && rdy)) begin
         if (pop) void'(q.pop_front());
         if (push) begin
            e.w = w;
            e.b = b;
            q.push_back(e);
         end
      end
      #1;
   endtask

   task automatic do_reset();
      rst                = 1'b1;
      flush              = 1'b0;
      idata_instr_valid  = 1'b0;
      idata_instr        = '0;
      instr_bank_counter = '0;
      instr_out_ready    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      q.delete();
   endtask

   initial begin
      logic [SW-1:0] w0, held;
      logic          v, r, f;

      // Reset state and three pushes to banks 2, 5, 2
      do_reset();
      #1;
      check("rst_count", SW'(count), '0);
      check("rst_empty", SW'(empty), SW'(1));
      check("rst_full", SW'(full), '0);
      check("rst_valid", SW'(instr_out_valid), '0);
      check("rst_pending", SW'(bank_pending), '0);
      check("rst_ready", SW'(idata_instr_ready), SW'(1));
      w0 = rand_word();
      step(1'b1, w0, 4'd2, 1'b0, 1'b0);
      step(1'b1, rand_word(), 4'd5, 1'b0, 1'b0);
      step(1'b1, rand_word(), 4'd2, 1'b0, 1'b0);
      check("tp1_count", SW'(count), SW'(3));
      check("tp1_pending", SW'(bank_pending), SW'(16'h0024));
      check("tp1_head", instr_out, w0);
      check("tp1_bank", SW'(instr_out_bank), SW'(2));

      // Fill to full, hold a ninth word, pop one, then accept it
      do_reset();
      for (int i = 0; i < DEPTH; i++) step(1'b1, rand_word(), BW'(i), 1'b0, 1'b0);
      check("tp2_full", SW'(full), SW'(1));
      check("tp2_ready", SW'(idata_instr_ready), '0);
      held = rand_word();
      step(1'b1, held, 4'd9, 1'b0, 1'b0);
      check("tp2_hold_count", SW'(count), SW'(8));
      step(1'b1, held, 4'd9, 1'b1, 1'b0);
      check("tp2_pop_count", SW'(count), SW'(7));
      step(1'b1, held, 4'd9, 1'b0, 1'b0);
      check("tp2_refill_count", SW'(count), SW'(8));
      for (int i = 0; i < DEPTH; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
      check("tp2_drained", SW'(empty), SW'(1));

      // Sustained push and pop across pointer wrap
      do_reset();
      step(1'b1, rand_word(), 4'($urandom), 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         step(1'b1, rand_word(), 4'($urandom), 1'b1, 1'b0);
         check("tp3_count", SW'(count), SW'(1));
      end
      step(1'b0, '0, '0, 1'b1, 1'b0);

      // Same-bank push and pop cancel
      do_reset();
      step(1'b1, rand_word(), 4'd3, 1'b0, 1'b0);
      step(1'b1, rand_word(), 4'd3, 1'b1, 1'b0);
      check("tp4_pending3", SW'(bank_pending[3]), SW'(1));
      check("tp4_count", SW'(count), SW'(1));
      step(1'b0, '0, '0, 1'b1, 1'b0);
      check("tp4_cleared", SW'(bank_pending), '0);

      // Flush beats simultaneous push and pop
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b1, rand_word(), BW'(i + 1), 1'b0, 1'b0);
      step(1'b1, rand_word(), 4'd1, 1'b1, 1'b1);
      check("tp5_count", SW'(count), '0);
      check("tp5_empty", SW'(empty), SW'(1));
      check("tp5_pending", SW'(bank_pending), '0);
      step(1'b0, '0, '0, 1'b0, 1'b0);

      // Empty buffer, word 0xA5 bank 7 with consumer ready
      do_reset();
      step(1'b1, SW'(8'hA5), 4'd7, 1'b1, 1'b0);
      check("tp6_count", SW'(count), BYP ? '0 : SW'(1));
      step(1'b0, '0, '0, 1'b1, 1'b0);

      // Random traffic with occasional flush
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         v = ($urandom_range(0, 3) != 0);
         r = (i % 600 < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         f = ($urandom_range(0, 63) == 0);
         step(v, rand_word(), 4'($urandom), r, f);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
